// File: rtl/bcd_countdown_pkg.sv
// Shared constants for the BCD countdown timer: state encoding, digit width,
// largest legal BCD digit and a digit saturation helper.
package bcd_countdown_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    // Clamp a non-BCD nibble (A..F) to 9.
    function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Command/status bundle of the BCD countdown timer. The master drives the
// commands and the preset; the slave (the counter) drives count and status.
interface bcd_countdown_if
    import bcd_countdown_pkg::*;
#(
    parameter int D = 3
);

    logic               Tick;
    logic               Load;
    logic               Start;
    logic               Stop;
    logic [BCD_W*D-1:0] Preset;
    logic [BCD_W*D-1:0] Q;
    logic               Running;
    logic               Done;

    modport master (
        output Tick, Load, Start, Stop, Preset,
        input  Q, Running, Done
    );

    modport slave (
        input  Tick, Load, Start, Stop, Preset,
        output Q, Running, Done
    );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the decrement chain: decrements when Dec is set, wrapping
// 0 -> 9 and requesting a borrow from the next more significant digit.
module bcd_digit_down
    import bcd_countdown_pkg::*;
(
    input  logic             Dec,
    input  logic [BCD_W-1:0] Din,
    output logic [BCD_W-1:0] Dout,
    output logic             Borrow_out
);

    // Combinational decrement with wrap and borrow generation.
    always_comb begin
        Borrow_out = Dec && (Din == '0);
        if (!Dec) begin
            Dout = Din;
        end else if (Din == '0) begin
            Dout = BCD_MAX;
        end else begin
            Dout = Din - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Programmable D-digit BCD countdown timer. Counts down one unit per Tick in
// RUN, stops at zero with a one-cycle Done pulse.
// Optional feature: define BCD_COUNTDOWN_AUTORELOAD_EN to reload the preset on
// expiry and keep running periodically.
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int D = 3
)(
    input  logic Clock,
    input  logic Reset_n,
    bcd_countdown_if.slave bus
);

    localparam int W = BCD_W * D;

    logic [1:0]   state, state_nxt;
    logic [W-1:0] q_reg, q_nxt;
    logic [W-1:0] reload_reg, reload_nxt;
    logic         done_reg, done_nxt;
    logic         running_reg;
    logic [W-1:0] preset_sat;
    logic [W-1:0] dec_q;
    logic [D:0]   borrow;
    logic         q_is_zero;
    logic         q_is_one;

    // Saturate every preset digit to a legal BCD value.
    always_comb begin
        preset_sat = '0;
        for (int unsigned i = 0; i < D; i++) begin
            preset_sat[i*BCD_W +: BCD_W] = bcd_sat(bus.Preset[i*BCD_W +: BCD_W]);
        end
    end

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < D; i++) begin : g_digit
        bcd_digit_down u_digit (
            .Dec        (borrow[i]),
            .Din        (q_reg[i*BCD_W +: BCD_W]),
            .Dout       (dec_q[i*BCD_W +: BCD_W]),
            .Borrow_out (borrow[i+1])
        );
    end

    // A borrow out of the top digit means every digit is already zero, so the
    // chain doubles as the zero detector.
    assign q_is_zero = borrow[D];
    assign q_is_one  = (q_reg == W'(1));

    // Next-state logic; command priority is Load > Stop > Start > Tick.
    always_comb begin
        state_nxt  = state;
        q_nxt      = q_reg;
        reload_nxt = reload_reg;
        done_nxt   = 1'b0;
        if (bus.Load) begin
            q_nxt      = preset_sat;
            reload_nxt = preset_sat;
            state_nxt  = IDLE;
        end else if (bus.Stop && state == RUN) begin
            state_nxt = IDLE;
        end else if (bus.Start && state == IDLE && !q_is_zero) begin
            state_nxt = RUN;
        end else if (bus.Start && state == EXPIRED && reload_reg != '0) begin
            q_nxt     = reload_reg;
            state_nxt = RUN;
        end else if (bus.Tick && state == RUN) begin
            if (q_is_one) begin
                done_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                if (reload_reg != '0) begin
                    q_nxt = reload_reg;
                end else begin
                    q_nxt     = '0;
                    state_nxt = EXPIRED;
                end
`else
                q_nxt     = '0;
                state_nxt = EXPIRED;
`endif
            end else begin
                q_nxt = dec_q;
            end
        end
    end

    // State, count, reload and status registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            reload_reg  <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state       <= state_nxt;
            q_reg       <= q_nxt;
            reload_reg  <= reload_nxt;
            done_reg    <= done_nxt;
            running_reg <= (state_nxt == RUN);
        end
    end

    assign bus.Q       = q_reg;
    assign bus.Running = running_reg;
    assign bus.Done    = done_reg;

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown (D=3). A decimal-arithmetic model is
// compared against the DUT on every falling edge; directed literal checks pin
// the model. Honours BCD_COUNTDOWN_AUTORELOAD_EN.
module tb_bcd_countdown;

    localparam int D = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_countdown_if #(.D(D)) bus ();

    bcd_countdown #(.D(D)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: decimal count value, reload value, 0 idle / 1 run / 2 expired.
    int mv    = 0;
    int mr    = 0;
    int mst   = 0;
    bit mdone = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_val(input logic [11:0] p);
        int v = 0;
        int m = 1;
        for (int i = 0; i < D; i++) begin
            int d = int'((p >> (4 * i)) & 12'hF);
            if (d > 9) d = 9;
            v += d * m;
            m *= 10;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Behavioural model, plain decimal arithmetic on the count value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv = 0; mr = 0; mst = 0; mdone = 1'b0;
        end else begin
            mdone = 1'b0;
            if (bus.Load) begin
                mv = sat_val(bus.Preset); mr = mv; mst = 0;
            end else if (bus.Stop && mst == 1) begin
                mst = 0;
            end else if (bus.Start && mst == 0 && mv != 0) begin
                mst = 1;
            end else if (bus.Start && mst == 2 && mr != 0) begin
                mv = mr; mst = 1;
            end else if (bus.Tick && mst == 1) begin
                if (mv == 1) begin
                    mdone = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                    mv = mr;
`else
                    mv = 0; mst = 2;
`endif
                end else begin
                    mv = mv - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmp_q", 32'(bus.Q), 32'(to_bcd(mv)));
        chk("cmp_running", 32'(bus.Running), 32'(mst == 1));
        chk("cmp_done", 32'(bus.Done), 32'(mdone));
    end

    task automatic cyc(input bit tk, input bit ld, input bit sa, input bit so, input logic [11:0] pre);
        bus.Tick = tk; bus.Load = ld; bus.Start = sa; bus.Stop = so; bus.Preset = pre;
        @(posedge clk);
        #1;
        bus.Tick = 1'b0; bus.Load = 1'b0; bus.Start = 1'b0; bus.Stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick();    cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h000); endtask
    task automatic start();   cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000); endtask
    task automatic stop();    cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000); endtask
    task automatic load(input logic [11:0] p); cyc(1'b0, 1'b1, 1'b0, 1'b0, p); endtask

    initial begin
        int dcount;
        bus.Tick = 1'b0; bus.Load = 1'b0; bus.Start = 1'b0; bus.Stop = 1'b0; bus.Preset = '0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_q", 32'(bus.Q), 32'h000);
        chk("reset_running", 32'(bus.Running), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);

        start();
        chk("start_at_zero", 32'(bus.Running), 32'd0);

        // 5 -> 0 countdown; Tick alongside Start is not counted.
        load(12'h005);
        chk("load_005", 32'(bus.Q), 32'h005);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
        chk("start_tick_q", 32'(bus.Q), 32'h005);
        chk("start_running", 32'(bus.Running), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
            chk("count5_q", 32'(bus.Q), 32'(5 - i));
            chk("count5_done", 32'(bus.Done), 32'(i == 5));
            chk("count5_running", 32'(bus.Running), 32'(i != 5));
`endif
        end
        tick();
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
        chk("tick_after_expiry_q", 32'(bus.Q), 32'h000);
        chk("tick_after_expiry_done", 32'(bus.Done), 32'd0);
        start();
        chk("restart_expired_q", 32'(bus.Q), 32'h005);
        chk("restart_expired_running", 32'(bus.Running), 32'd1);
`endif
        stop();

        // Borrow ripple 100 -> 099, then run to zero.
        load(12'h100);
        start();
        tick();
        chk("wrap_100", 32'(bus.Q), 32'h099);
        dcount = 0;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (bus.Done) dcount++;
        end
`ifndef BCD_COUNTDOWN_AUTORELOAD_EN
        chk("run99_q", 32'(bus.Q), 32'h000);
        chk("run99_done_count", 32'(dcount), 32'd1);
`endif

        // Saturation of invalid digits.
        load(12'h0FA);
        chk("sat_0fa", 32'(bus.Q), 32'h099);

        // Stop coinciding with a tick loses the tick.
        load(12'h010);
        start();
        tick(); tick(); tick();
        chk("ten_minus3", 32'(bus.Q), 32'h007);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
        chk("stop_tick_q", 32'(bus.Q), 32'h007);
        chk("stop_running", 32'(bus.Running), 32'd0);
        tick();
        chk("paused_tick_q", 32'(bus.Q), 32'h007);
        start();
        tick();
        chk("resume_q", 32'(bus.Q), 32'h006);

        // Asynchronous reset mid-count.
        load(12'h050);
        start();
        for (int i = 0; i < 8; i++) tick();
        chk("pre_reset_q", 32'(bus.Q), 32'h042);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_q", 32'(bus.Q), 32'h000);
        chk("async_reset_running", 32'(bus.Running), 32'd0);
        chk("async_reset_done", 32'(bus.Done), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start();
        tick(); tick();
        chk("post_reset_q", 32'(bus.Q), 32'h000);
        chk("post_reset_running", 32'(bus.Running), 32'd0);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        begin
            logic [11:0] exp_q [7];
            exp_q = '{12'h002, 12'h001, 12'h003, 12'h002, 12'h001, 12'h003, 12'h002};
            load(12'h003);
            start();
            for (int i = 0; i < 7; i++) begin
                tick();
                chk("auto_q", 32'(bus.Q), 32'(exp_q[i]));
                chk("auto_done", 32'(bus.Done), 32'(i == 2 || i == 5));
                chk("auto_running", 32'(bus.Running), 32'd1);
            end
        end
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
